// File: rtl/updi_pkg.sv
// updi_pkg - shared definitions for the UPDI transmit path.
//   updi_tx_state_t    : transmitter FSM states
//   UPDI_DATA_BITS     : data bits per UPDI frame
//   UPDI_DEF_STOP_BITS : default number of stop bits
package updi_pkg;

  localparam int UPDI_DATA_BITS     = 8;
  localparam int UPDI_DEF_STOP_BITS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6,
    BREAK  = 3'd7
  } updi_tx_state_t;

endpackage

// File: rtl/updi_baud_gen.sv
// updi_baud_gen - bit-time counter for the UPDI transmitter.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   clr_i      : hold the counter at zero (asserted while no bit is on the line)
//   bit_tick_o : high on the last cycle of each bit time
//   pre_tick_o : high on the second-to-last cycle of each bit time
module updi_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic bit_tick_o,
  output logic pre_tick_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;

  assign bit_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // Lets the FSM register a pulse that lands on the last cycle of a bit.
  assign pre_tick_o = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

  // Counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || bit_tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/updi_tx.sv
// updi_tx - UPDI one-wire serial transmitter.
// Pops bytes from the TX FIFO and sends each as: start, 8 data bits LSB
// first, even parity, STOP_BITS stop bits.
//   clk, rst (async, active-low)
//   fifo_data/fifo_empty in, fifo_rd_en out : TX FIFO read side
//   break_req in : break request (used only with UPDI_TX_BREAK_EN defined)
//   tx, tx_en    : pad level and output enable (registered)
//   busy         : high outside IDLE
//   frame_done   : pulse in the last cycle of a frame or break
// Build option: define UPDI_TX_BREAK_EN to compile in break generation.
module updi_tx
  import updi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = UPDI_DEF_STOP_BITS,
  parameter int BREAK_BITS   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       break_req,
  output logic       tx,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done
);

  updi_tx_state_t state_q;
  logic [4:0]     bit_cnt_q;
  logic [7:0]     shreg_q;
  logic           parity_q;
  logic           tx_q;
  logic           tx_en_q;
  logic           rd_en_q;
  logic           busy_q;
  logic           done_q;

  logic           bit_tick_s;
  logic           pre_tick_s;
  logic           baud_clr_s;
  logic           last_stop_s;

`ifndef UPDI_TX_BREAK_EN
  logic unused_break_req_s;
  assign unused_break_req_s = break_req;
`endif

  // Counter is held in the non-line states so START/BREAK begin at count 0.
  assign baud_clr_s  = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);
  assign last_stop_s = (bit_cnt_q == 5'(STOP_BITS - 1));

  updi_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i      (clk),
    .rst_ni     (rst),
    .clr_i      (baud_clr_s),
    .bit_tick_o (bit_tick_s),
    .pre_tick_o (pre_tick_s)
  );

  // Transmit FSM with registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 5'd0;
      shreg_q   <= 8'h00;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      tx_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q    <= 1'b1;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
`ifdef UPDI_TX_BREAK_EN
          if (break_req) begin
            state_q   <= BREAK;
            bit_cnt_q <= 5'd0;
            tx_q      <= 1'b0;
            tx_en_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else
`endif
          if (!fifo_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          // FIFO data is valid now, one cycle after the pop.
          shreg_q  <= fifo_data;
          parity_q <= ^fifo_data;
          state_q  <= START;
          tx_q     <= 1'b0;
          tx_en_q  <= 1'b1;
        end
        START: begin
          if (bit_tick_s) begin
            state_q   <= DATA;
            bit_cnt_q <= 5'd0;
            tx_q      <= shreg_q[0];
          end
        end
        DATA: begin
          if (bit_tick_s) begin
            if (bit_cnt_q == 5'(UPDI_DATA_BITS - 1)) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
              shreg_q   <= {1'b0, shreg_q[7:1]};
              tx_q      <= shreg_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick_s) begin
            state_q   <= STOP;
            bit_cnt_q <= 5'd0;
            tx_q      <= 1'b1;
          end
        end
        STOP: begin
          if (last_stop_s && pre_tick_s) begin
            done_q <= 1'b1;
          end
          if (bit_tick_s) begin
            if (!last_stop_s) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              bit_cnt_q <= 5'd0;
              tx_en_q   <= 1'b0;
              if (!fifo_empty) begin
                state_q <= FETCH;
                rd_en_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
`ifdef UPDI_TX_BREAK_EN
        BREAK: begin
          // Low phase; the high phase reuses STOP so the exit rule is shared.
          if (bit_tick_s) begin
            if (bit_cnt_q == 5'(BREAK_BITS - 1)) begin
              state_q   <= STOP;
              bit_cnt_q <= 5'd0;
              tx_q      <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign tx_en      = tx_en_q;
  assign fifo_rd_en = rd_en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_updi_tx.sv
// tb_updi_tx - directed self-checking bench for updi_tx
// (CLKS_PER_BIT=4, STOP_BITS=2). Frame bit vectors are written with
// bit time 0 (start) in bit [0] through the last stop bit in bit [11].
module tb_updi_tx;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       break_req  = 1'b0;
  logic       fifo_rd_en;
  logic       tx;
  logic       tx_en;
  logic       busy;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic [7:0] fq[$];

  updi_tx #(
    .CLKS_PER_BIT (4),
    .STOP_BITS    (2),
    .BREAK_BITS   (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .break_req  (break_req),
    .tx         (tx),
    .tx_en      (tx_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: pops on negedge while fifo_rd_en is high, data valid next cycle.
  always @(negedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      if (fq.size() > 0) fifo_data = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  // Waits (bounded) for the start bit; ends on the negedge of START cycle 0.
  task automatic wait_start(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0 && tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Observes one 48-cycle frame starting at START cycle 0.
  task automatic sample_frame(output logic [11:0] bits, output int done_at,
                              output int n_done, output logic en_ok);
    bits = 12'h000; done_at = -1; n_done = 0; en_ok = 1'b1;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      if ((c % 4) == 2) bits[c/4] = tx;
      if (tx_en !== 1'b1 || fifo_rd_en !== 1'b0) en_ok = 1'b0;
      if (frame_done === 1'b1) begin
        n_done = n_done + 1;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx, tx_en, busy, fifo_rd_en, frame_done} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_hold: got %b want 10000", {tx, tx_en, busy, fifo_rd_en, frame_done});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx, tx_en, busy, fifo_rd_en, frame_done} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_release: got %b want 10000", {tx, tx_en, busy, fifo_rd_en, frame_done});
    end
  endtask

  task automatic test_single_55();
    logic [11:0] bits; int done_at; int n_done; logic en_ok; int r0;
    r0 = rd_cnt;
    @(posedge clk); #1 push(8'h55);
    @(negedge clk);                 // cycle N
    @(negedge clk);                 // N+1
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL rd_en_n1: got %b want 1", fifo_rd_en); end
    @(negedge clk);                 // N+2
    n_cmp++;
    if ({fifo_rd_en, tx, tx_en, busy} !== 4'b0101) begin
      n_err++; $display("FAIL load_cycle: got %b want 0101", {fifo_rd_en, tx, tx_en, busy});
    end
    @(negedge clk);                 // N+3
    n_cmp++;
    if ({tx, tx_en} !== 2'b01) begin n_err++; $display("FAIL start_n3: got %b want 01", {tx, tx_en}); end
    sample_frame(bits, done_at, n_done, en_ok);
    n_cmp++;
    if (bits !== 12'b110010101010) begin n_err++; $display("FAIL frame_55: got %b want 110010101010", bits); end
    n_cmp++;
    if (done_at != 47 || n_done != 1) begin
      n_err++; $display("FAIL done_55: at %0d count %0d want at 47 count 1", done_at, n_done);
    end
    n_cmp++;
    if (en_ok !== 1'b1) begin n_err++; $display("FAIL txen_55: got %b want 1", en_ok); end
    @(negedge clk); #1;
    n_cmp++;
    if ({tx, tx_en, busy} !== 3'b100 || rd_cnt - r0 != 1) begin
      n_err++; $display("FAIL idle_55: got %b pops %0d want 100 pops 1", {tx, tx_en, busy}, rd_cnt - r0);
    end
  endtask

  task automatic test_parity_01();
    logic [11:0] bits; int done_at; int n_done; logic en_ok; logic ok;
    @(posedge clk); #1 push(8'h01);
    wait_start(ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL start_01: got timeout want start"); end
    sample_frame(bits, done_at, n_done, en_ok);
    n_cmp++;
    if (bits[9] !== 1'b1) begin n_err++; $display("FAIL parity_01: got %b want 1", bits[9]); end
    n_cmp++;
    if (bits !== 12'b111000000010) begin n_err++; $display("FAIL frame_01: got %b want 111000000010", bits); end
    n_cmp++;
    if (done_at != 47 || n_done != 1 || en_ok !== 1'b1) begin
      n_err++; $display("FAIL done_01: at %0d count %0d en %b want 47 1 1", done_at, n_done, en_ok);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] bits; int done_at; int n_done; logic en_ok; logic ok; logic idle_ok; int r0;
    r0 = rd_cnt;
    @(posedge clk); #1 push(8'hA5); push(8'h3C);
    wait_start(ok);
    sample_frame(bits, done_at, n_done, en_ok);
    n_cmp++;
    if (ok !== 1'b1 || bits !== 12'b110101001010 || bits[9] !== 1'b0) begin
      n_err++; $display("FAIL frame_a5: got %b want 110101001010", bits);
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, tx_en, fifo_rd_en, busy} !== 4'b1011) begin
      n_err++; $display("FAIL gap1: got %b want 1011", {tx, tx_en, fifo_rd_en, busy});
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, tx_en, fifo_rd_en} !== 3'b100) begin
      n_err++; $display("FAIL gap2: got %b want 100", {tx, tx_en, fifo_rd_en});
    end
    @(negedge clk);
    n_cmp++;
    if ({tx, tx_en} !== 2'b01) begin n_err++; $display("FAIL start_3c: got %b want 01", {tx, tx_en}); end
    sample_frame(bits, done_at, n_done, en_ok);
    n_cmp++;
    if (bits !== 12'b110001111000 || bits[9] !== 1'b0) begin
      n_err++; $display("FAIL frame_3c: got %b want 110001111000", bits);
    end
    n_cmp++;
    if (done_at != 47 || n_done != 1 || en_ok !== 1'b1) begin
      n_err++; $display("FAIL done_3c: at %0d count %0d en %b want 47 1 1", done_at, n_done, en_ok);
    end
    idle_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({tx, tx_en, busy} !== 3'b100) idle_ok = 1'b0;
    end
    #1;
    n_cmp++;
    if (idle_ok !== 1'b1 || rd_cnt - r0 != 2) begin
      n_err++; $display("FAIL empty_after_3c: idle %b pops %0d want 1 pops 2", idle_ok, rd_cnt - r0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] bits; int done_at; int n_done; logic en_ok; logic ok; logic idle_ok; int r0;
    r0 = rd_cnt;
    @(posedge clk); #1 push(8'hF0);
    wait_start(ok);
    repeat (17) @(negedge clk);     // inside data bit 3
    n_cmp++;
    if ({tx, tx_en, busy} !== 3'b011) begin
      n_err++; $display("FAIL pre_rst_f0: got %b want 011", {tx, tx_en, busy});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({tx, tx_en, busy, fifo_rd_en} !== 4'b1000) begin
      n_err++; $display("FAIL async_rst: got %b want 1000", {tx, tx_en, busy, fifo_rd_en});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({tx, tx_en, busy, fifo_rd_en} !== 4'b1000) idle_ok = 1'b0;
    end
    #1;
    n_cmp++;
    if (idle_ok !== 1'b1 || rd_cnt - r0 != 1) begin
      n_err++; $display("FAIL no_retx: idle %b pops %0d want 1 pops 1", idle_ok, rd_cnt - r0);
    end
    @(posedge clk); #1 push(8'h55);
    wait_start(ok);
    sample_frame(bits, done_at, n_done, en_ok);
    #1;
    n_cmp++;
    if (ok !== 1'b1 || bits !== 12'b110010101010 || rd_cnt - r0 != 2) begin
      n_err++; $display("FAIL after_rst_55: got %b pops %0d want 110010101010 pops 2", bits, rd_cnt - r0);
    end
    @(negedge clk);
  endtask

`ifdef UPDI_TX_BREAK_EN
  task automatic test_break();
    logic [11:0] bits; int done_at; int n_done; logic en_ok; logic ok;
    logic lo_ok; logic hi_ok; int r0; int brk_done_at; int brk_dn;
    r0 = rd_cnt; lo_ok = 1'b1; hi_ok = 1'b1; brk_done_at = -1; brk_dn = 0;
    @(posedge clk); #1 break_req = 1'b1; push(8'hAA);
    @(negedge clk);
    @(negedge clk);                 // break cycle 0
    break_req = 1'b0;
    for (int c = 0; c < 56; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 48 && {tx, tx_en, busy, fifo_rd_en} !== 4'b0110) lo_ok = 1'b0;
      if (c >= 48 && {tx, tx_en, busy, fifo_rd_en} !== 4'b1110) hi_ok = 1'b0;
      if (frame_done === 1'b1) begin
        brk_dn = brk_dn + 1;
        if (brk_done_at < 0) brk_done_at = c;
      end
    end
    n_cmp++;
    if (lo_ok !== 1'b1) begin n_err++; $display("FAIL break_low: got %b want 1", lo_ok); end
    n_cmp++;
    if (hi_ok !== 1'b1) begin n_err++; $display("FAIL break_high: got %b want 1", hi_ok); end
    n_cmp++;
    if (brk_done_at != 55 || brk_dn != 1) begin
      n_err++; $display("FAIL break_done: at %0d count %0d want 55 1", brk_done_at, brk_dn);
    end
    @(negedge clk);
    n_cmp++;
    if ({fifo_rd_en, tx, tx_en} !== 3'b110) begin
      n_err++; $display("FAIL break_fetch: got %b want 110", {fifo_rd_en, tx, tx_en});
    end
    wait_start(ok);
    sample_frame(bits, done_at, n_done, en_ok);
    n_cmp++;
    if (ok !== 1'b1 || bits !== 12'b110101010100 || done_at != 47) begin
      n_err++; $display("FAIL frame_aa: got %b done %0d want 110101010100 done 47", bits, done_at);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_break_ignored();
    logic idle_ok;
    idle_ok = 1'b1;
    @(posedge clk); #1 break_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({tx, tx_en, busy, fifo_rd_en} !== 4'b1000) idle_ok = 1'b0;
    end
    break_req = 1'b0;
    n_cmp++;
    if (idle_ok !== 1'b1) begin n_err++; $display("FAIL break_ignored: got %b want 1", idle_ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_55();
    test_parity_01();
    test_back_to_back();
    test_reset_midframe();
`ifdef UPDI_TX_BREAK_EN
    test_break();
`else
    test_break_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
